// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: 2-entry in-order skid buffer between fetch and decode.
// Optional `IF_ID_BUBBLE_CNT_EN adds a saturating 16-bit decode bubble counter output.
module if_id_pipe_reg #(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          PC_INC    = 4,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h00000013)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
`ifdef IF_ID_BUBBLE_CNT_EN
  output logic [15:0]        bubble_cnt,
`endif
  output logic [PC_W-1:0]    out_pc_next
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] head_instr_q, head_instr_d;
  logic [PC_W-1:0]    head_pc_q, head_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

  logic accept;
  logic pop;

  // in_ready drops combinationally with reset so nothing is taken while held in reset.
  assign in_ready  = (state_q != StTwo) & reset;
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d      = StOne;
          head_instr_d = in_instr;
          head_pc_d    = in_pc;
        end
      end
      StOne: begin
        if (accept && pop) begin
          head_instr_d = in_instr;
          head_pc_d    = in_pc;
        end else if (accept) begin
          state_d      = StTwo;
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // Full: no accept possible, so a pop just promotes the skid entry.
        if (pop) begin
          state_d      = StOne;
          head_instr_d = skid_instr_q;
          head_pc_d    = skid_pc_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      head_instr_q <= NOP_INSTR;
      head_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    out_instr   = NOP_INSTR;
    out_pc      = '0;
    out_pc_next = '0;
    if (out_valid) begin
      out_instr   = head_instr_q;
      out_pc      = head_pc_q;
      out_pc_next = head_pc_q + PC_W'(PC_INC);
    end
  end

`ifdef IF_ID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (out_ready && !out_valid && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Self-checking bench for if_id_pipe_reg: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_if_id_pipe_reg;

  localparam logic [31:0] Nop = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
`ifdef IF_ID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, head at index 0, capacity 2.
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc[$];

  if_id_pipe_reg dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
`ifdef IF_ID_BUBBLE_CNT_EN
    .bubble_cnt (bubble_cnt),
`endif
    .out_pc_next(out_pc_next)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    bit has = (mq_pc.size() > 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq_pc.size() < 2));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(has));
    chk({tag, ".out_instr"}, out_instr, has ? mq_instr[0] : Nop);
    chk({tag, ".out_pc"}, out_pc, has ? mq_pc[0] : 32'h0);
    chk({tag, ".out_pc_next"}, out_pc_next, has ? mq_pc[0] + 32'd4 : 32'h0);
  endtask

  // Drive one cycle of inputs, advance one edge, update the model, then compare.
  task automatic step(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                      input logic ordy, input logic fl, input string tag);
    bit acc, pp;
    in_valid  = iv;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = iv && (mq_pc.size() < 2);
    pp  = ordy && (mq_pc.size() > 0);
    @(posedge clk);
    if (fl) begin
      mq_instr.delete();
      mq_pc.delete();
    end else begin
      if (pp) begin
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (acc) begin
        mq_instr.push_back(instr);
        mq_pc.push_back(pc);
      end
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_instr", out_instr, Nop);
    chk("rst.out_pc", out_pc, 32'h0);
    chk("rst.out_pc_next", out_pc_next, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_model("idle");

    // Latency 1 from empty.
    step(1'b1, 32'h00A00093, 32'h100, 1'b1, 1'b0, "lat");
    chk("lat.valid", 32'(out_valid), 32'd1);
    chk("lat.instr", out_instr, 32'h00A00093);
    chk("lat.pc", out_pc, 32'h100);
    chk("lat.pc_next", out_pc_next, 32'h104);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain0");

    // Back-pressure: two accepted, third stalls, then drains in order.
    step(1'b1, 32'h11111111, 32'h0, 1'b0, 1'b0, "bp0");
    step(1'b1, 32'h22222222, 32'h4, 1'b0, 1'b0, "bp1");
    chk("bp.full_in_ready", 32'(in_ready), 32'd0);
    chk("bp.head0", out_pc, 32'h0);
    step(1'b1, 32'h33333333, 32'h8, 1'b0, 1'b0, "bp2");
    chk("bp.hold_pc", out_pc, 32'h0);
    chk("bp.hold_instr", out_instr, 32'h11111111);
    step(1'b1, 32'h33333333, 32'h8, 1'b1, 1'b0, "bp3");
    chk("bp.head1", out_pc, 32'h4);
    step(1'b1, 32'h33333333, 32'h8, 1'b1, 1'b0, "bp4");
    chk("bp.head2", out_pc, 32'h8);
    chk("bp.head2_instr", out_instr, 32'h33333333);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bp5");
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Flush from TWO and from ONE with a same-cycle accept.
    step(1'b1, 32'hAAAA0001, 32'h20, 1'b0, 1'b0, "fl0");
    step(1'b1, 32'hAAAA0002, 32'h24, 1'b0, 1'b0, "fl1");
    step(1'b1, 32'hAAAA0003, 32'h28, 1'b0, 1'b1, "fl2");
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.instr", out_instr, Nop);
    chk("fl.in_ready", 32'(in_ready), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "fl3");
    chk("fl.gone", 32'(out_valid), 32'd0);
    step(1'b1, 32'hBBBB0001, 32'h30, 1'b0, 1'b0, "fl4");
    step(1'b1, 32'hBBBB0002, 32'h34, 1'b1, 1'b1, "fl5");
    chk("fl.one_valid", 32'(out_valid), 32'd0);

    // PC wrap.
    step(1'b1, 32'hCCCC0001, 32'hFFFFFFFC, 1'b0, 1'b0, "wrap");
    chk("wrap.pc_next", out_pc_next, 32'h00000000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "wrap_drain");

    // Asynchronous reset mid-cycle while holding one entry.
    step(1'b1, 32'hDDDD0001, 32'h200, 1'b0, 1'b0, "ar0");
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ar.valid", 32'(out_valid), 32'd0);
    chk("ar.in_ready", 32'(in_ready), 32'd0);
    chk("ar.instr", out_instr, Nop);
    chk("ar.pc", out_pc, 32'h0);
    chk("ar.pc_next", out_pc_next, 32'h0);
    mq_instr.delete();
    mq_pc.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ar.resume_ready", 32'(in_ready), 32'd1);
    chk("ar.resume_valid", 32'(out_valid), 32'd0);

`ifdef IF_ID_BUBBLE_CNT_EN
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bub");
    chk("bub.count5", 32'(bubble_cnt), 32'd5);
    force dut.bubble_cnt_q = 16'hFFFF;
    #1;
    release dut.bubble_cnt_q;
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bub_sat");
    chk("bub.saturate", 32'(bubble_cnt), 32'h0000FFFF);
    step(1'b1, 32'h0, 32'h0, 1'b1, 1'b1, "bub_flush");
    chk("bub.flush_keeps", 32'(bubble_cnt), 32'h0000FFFF);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom(), $urandom() & 32'hFFFFFFFC,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
